reg_file_rename: RTL

Architectural register file with per-register rename status for the out-of-order core: each entry holds a value, a busy bit and the ROB tag of its pending producer. Dispatch reads two source operands (value, busy, tag) and renames the destination; commit writes values back and clears busy only when the committing tag is still the newest producer. A flush clears all rename state after a mispredict. It is the parametrised successor to the plain two-read/one-write register file, generalising width, depth and tag size.

---
 rtl/reg_file_rename_pkg.sv | 9 +
 rtl/reg_file_rename_read_port.sv | 74 +++++++
 rtl/reg_file_rename.sv | 78 +++++++
 3 files changed

// File: rtl/reg_file_rename_pkg.sv
// Shared sizing defaults for the rename register file, ROB and dispatch.
// Also holds the hard-wired zero register index.
package reg_file_rename_pkg;
  localparam int DEF_LEN     = 32;
  localparam int DEF_REG_NUM = 32;
  localparam int DEF_REG_AW  = $clog2(DEF_REG_NUM);
  localparam int DEF_TAG_W   = 4;
  localparam int ZERO_REG    = 0;
endpackage

// File: rtl/reg_file_rename_read_port.sv
// One registered read port: zero-register handling, commit bypass and flush masking.
// Output is a function of pre-edge state, so a same-edge rename is never seen.
module reg_file_read_port
  import reg_file_rename_pkg::*;
#(
  parameter int LEN     = DEF_LEN,
  parameter int REG_NUM = DEF_REG_NUM,
  parameter int TAG_W   = DEF_TAG_W,
  localparam int REG_AW = $clog2(REG_NUM)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              rdy_in,
  input  logic [REG_AW-1:0]                 idx,
  input  logic [REG_NUM-1:0][LEN-1:0]       values,
  input  logic [REG_NUM-1:0]                busy,
  input  logic [REG_NUM-1:0][TAG_W-1:0]     tags,
  input  logic                              commit_flag,
  input  logic [REG_AW-1:0]                 commit_rd,
  input  logic [TAG_W-1:0]                  commit_tag,
  input  logic [LEN-1:0]                    commit_data,
  input  logic                              flush,
  output logic [LEN-1:0]                    data,
  output logic                              data_busy,
  output logic [TAG_W-1:0]                  data_tag
);

  logic [LEN-1:0]   nxt_data;
  logic             nxt_busy;
  logic [TAG_W-1:0] nxt_tag;

  always_comb begin
    nxt_data = values[idx];
    nxt_busy = busy[idx];
    nxt_tag  = tags[idx];
    if (idx == REG_AW'(ZERO_REG)) begin
      nxt_data = '0;
      nxt_busy = 1'b0;
    end else if (commit_flag && (commit_rd == idx)) begin
      nxt_data = commit_data;
      // Only the newest producer committing releases the register.
      if (busy[idx] && (tags[idx] == commit_tag)) begin
        nxt_busy = 1'b0;
      end else begin
        nxt_busy = busy[idx];
      end
    end else begin
      nxt_data = values[idx];
    end
    if (flush) begin
      nxt_busy = 1'b0;
    end else begin
      nxt_busy = nxt_busy;
    end
    if (!nxt_busy) begin
      nxt_tag = '0;
    end else begin
      nxt_tag = nxt_tag;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data      <= '0;
      data_busy <= 1'b0;
      data_tag  <= '0;
    end else if (rdy_in) begin
      data      <= nxt_data;
      data_busy <= nxt_busy;
      data_tag  <= nxt_tag;
    end
  end

endmodule

// File: rtl/reg_file_rename.sv
// Architectural register file with per-entry busy bit and producer ROB tag.
// Commit writes values, rename marks producers, flush drops all rename state.
module reg_file_rename
  import reg_file_rename_pkg::*;
#(
  parameter int LEN     = DEF_LEN,
  parameter int REG_NUM = DEF_REG_NUM,
  parameter int TAG_W   = DEF_TAG_W,
  localparam int REG_AW = $clog2(REG_NUM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy_in,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic              rename_flag,
  input  logic [REG_AW-1:0] rename_rd,
  input  logic [TAG_W-1:0]  rename_tag,
  input  logic              commit_flag,
  input  logic [REG_AW-1:0] commit_rd,
  input  logic [TAG_W-1:0]  commit_tag,
  input  logic [LEN-1:0]    commit_data,
  input  logic              flush,
  output logic [LEN-1:0]    rs1_data,
  output logic [LEN-1:0]    rs2_data,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic [TAG_W-1:0]  rs1_tag,
  output logic [TAG_W-1:0]  rs2_tag
);

  logic [REG_NUM-1:0][LEN-1:0]   values;
  logic [REG_NUM-1:0]            busy;
  logic [REG_NUM-1:0][TAG_W-1:0] tags;

  // Entry 0 is only ever touched by reset, so it stays zero and idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      values <= '0;
      busy   <= '0;
      tags   <= '0;
    end else if (rdy_in) begin
      for (int i = 1; i < REG_NUM; i++) begin
        if (commit_flag && (commit_rd == REG_AW'(i))) begin
          values[i] <= commit_data;
        end
        // Flush beats rename; rename beats a same-edge commit release.
        if (flush) begin
          busy[i] <= 1'b0;
          tags[i] <= '0;
        end else if (rename_flag && (rename_rd == REG_AW'(i))) begin
          busy[i] <= 1'b1;
          tags[i] <= rename_tag;
        end else if (commit_flag && (commit_rd == REG_AW'(i)) && busy[i]
                     && (tags[i] == commit_tag)) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end

  reg_file_read_port #(.LEN(LEN), .REG_NUM(REG_NUM), .TAG_W(TAG_W)) u_port1 (
    .clk(clk), .rst(rst), .rdy_in(rdy_in), .idx(rs1),
    .values(values), .busy(busy), .tags(tags),
    .commit_flag(commit_flag), .commit_rd(commit_rd), .commit_tag(commit_tag),
    .commit_data(commit_data), .flush(flush),
    .data(rs1_data), .data_busy(rs1_busy), .data_tag(rs1_tag)
  );

  reg_file_read_port #(.LEN(LEN), .REG_NUM(REG_NUM), .TAG_W(TAG_W)) u_port2 (
    .clk(clk), .rst(rst), .rdy_in(rdy_in), .idx(rs2),
    .values(values), .busy(busy), .tags(tags),
    .commit_flag(commit_flag), .commit_rd(commit_rd), .commit_tag(commit_tag),
    .commit_data(commit_data), .flush(flush),
    .data(rs2_data), .data_busy(rs2_busy), .data_tag(rs2_tag)
  );

endmodule
